// File: rtl/veriyolu.sv
// Single-bus datapath: three registers (A, B, AR) and two external sources drive a
// shared 8-bit bus through per-bit AND masks, OR-combined; A and B feed a combinational ALU.
module veriyolu (
  input  logic       aclk,
  input  logic       arst,
  input  logic [2:0] alu_sel,
  input  logic [7:0] a_yolla,
  input  logic [7:0] b_yolla,
  input  logic [7:0] ar_yolla,
  input  logic [7:0] s1_yolla,
  input  logic [7:0] s2_yolla,
  input  logic [7:0] s1,
  input  logic [7:0] s2,
  input  logic       a_yukle,
  input  logic       b_yukle,
  input  logic       ar_yukle,
  output logic [7:0] to_memory,
  output logic [7:0] m_address,
  output logic [7:0] a_tb,
  output logic [7:0] b_tb,
  output logic [7:0] alu_result_tb
);

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_NOT = 3'd5,
    ALU_SHL = 3'd6,
    ALU_SHR = 3'd7
  } alu_op_e;

  logic [7:0] a_q, b_q, ar_q;
  logic [7:0] bus;
  logic [7:0] alu_result;

  // Masked sources are OR-combined, so overlapping drivers merge and an idle bus reads 00.
  assign bus = (a_q  & a_yolla)  |
               (b_q  & b_yolla)  |
               (ar_q & ar_yolla) |
               (s1   & s1_yolla) |
               (s2   & s2_yolla);

  // NOTE: non-blocking assignments make every register sample the pre-edge bus, so a
  // register can drive the bus and load from it in the same cycle without a race.
  always_ff @(posedge aclk) begin
    if (arst) begin
      a_q  <= 8'h00;
      b_q  <= 8'h00;
      ar_q <= 8'h00;
    end else begin
      if (a_yukle)  a_q  <= bus;
      if (b_yukle)  b_q  <= bus;
      if (ar_yukle) ar_q <= bus;
    end
  end

  // NOTE: the result gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    alu_result = 8'h00;
    case (alu_op_e'(alu_sel))
      ALU_ADD: alu_result = a_q + b_q;
      ALU_SUB: alu_result = a_q - b_q;
      ALU_AND: alu_result = a_q & b_q;
      ALU_OR:  alu_result = a_q | b_q;
      ALU_XOR: alu_result = a_q ^ b_q;
      ALU_NOT: alu_result = ~a_q;
      ALU_SHL: alu_result = {a_q[6:0], 1'b0};
      ALU_SHR: alu_result = {1'b0, a_q[7:1]};
      default: alu_result = 8'h00;
    endcase
  end

  assign to_memory     = bus;
  assign m_address     = ar_q;
  assign a_tb          = a_q;
  assign b_tb          = b_q;
  assign alu_result_tb = alu_result;

endmodule

// File: tb/tb_veriyolu.sv
// Self-checking bench for veriyolu: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model of the datapath.
module tb_veriyolu;

  logic       aclk = 1'b0;
  logic       arst;
  logic [2:0] alu_sel;
  logic [7:0] a_yolla, b_yolla, ar_yolla, s1_yolla, s2_yolla;
  logic [7:0] s1, s2;
  logic       a_yukle, b_yukle, ar_yukle;
  logic [7:0] to_memory, m_address, a_tb, b_tb, alu_result_tb;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  logic [7:0] m_a, m_b, m_ar;
  bit         model_valid = 1'b0;

  always #5 aclk = ~aclk;

  veriyolu dut (
    .aclk          (aclk),
    .arst          (arst),
    .alu_sel       (alu_sel),
    .a_yolla       (a_yolla),
    .b_yolla       (b_yolla),
    .ar_yolla      (ar_yolla),
    .s1_yolla      (s1_yolla),
    .s2_yolla      (s2_yolla),
    .s1            (s1),
    .s2            (s2),
    .a_yukle       (a_yukle),
    .b_yukle       (b_yukle),
    .ar_yukle      (ar_yukle),
    .to_memory     (to_memory),
    .m_address     (m_address),
    .a_tb          (a_tb),
    .b_tb          (b_tb),
    .alu_result_tb (alu_result_tb)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bit i of the bus is 1 when any source both holds a 1 there and has its mask bit set.
  function automatic logic [7:0] model_bus();
    logic [7:0] src [5];
    logic [7:0] msk [5];
    logic [7:0] r;
    src[0] = m_a;  msk[0] = a_yolla;
    src[1] = m_b;  msk[1] = b_yolla;
    src[2] = m_ar; msk[2] = ar_yolla;
    src[3] = s1;   msk[3] = s1_yolla;
    src[4] = s2;   msk[4] = s2_yolla;
    r = 8'h00;
    for (int bit_i = 0; bit_i < 8; bit_i++)
      for (int k = 0; k < 5; k++)
        if (src[k][bit_i] === 1'b1 && msk[k][bit_i] === 1'b1) r[bit_i] = 1'b1;
    return r;
  endfunction

  function automatic logic [7:0] model_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] sel);
    int ai = int'(a);
    int bi = int'(b);
    int r  = 0;
    case (sel)
      3'd0: r = (ai + bi) % 256;
      3'd1: r = (ai - bi + 256) % 256;
      3'd2: r = int'(a & b);
      3'd3: r = int'(a | b);
      3'd4: r = int'(a ^ b);
      3'd5: r = 255 - ai;
      3'd6: r = (ai * 2) % 256;
      3'd7: r = ai / 2;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // Model register update at the active edge, from inputs that are stable around it.
  always @(posedge aclk) begin
    logic [7:0] bus_now;
    bus_now = model_bus();
    if (arst) begin
      m_a = 8'h00; m_b = 8'h00; m_ar = 8'h00;
      model_valid = 1'b1;
    end else begin
      if (a_yukle)  m_a  = bus_now;
      if (b_yukle)  m_b  = bus_now;
      if (ar_yukle) m_ar = bus_now;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge aclk) begin
    if (model_valid) begin
      check("cmp_to_memory", to_memory,     model_bus());
      check("cmp_m_address", m_address,     m_ar);
      check("cmp_a_tb",      a_tb,          m_a);
      check("cmp_b_tb",      b_tb,          m_b);
      check("cmp_alu",       alu_result_tb, model_alu(m_a, m_b, alu_sel));
    end
  end

  task automatic clear_inputs();
    arst = 1'b0; alu_sel = 3'd0;
    a_yolla = 8'h00; b_yolla = 8'h00; ar_yolla = 8'h00; s1_yolla = 8'h00; s2_yolla = 8'h00;
    a_yukle = 1'b0; b_yukle = 1'b0; ar_yukle = 1'b0;
  endtask

  // Advance past one rising edge, landing 2 time units after it.
  task automatic step();
    @(posedge aclk);
    #2;
  endtask

  function automatic logic [7:0] rand_mask();
    case ($urandom_range(3))
      0: return 8'h00;
      1: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    clear_inputs();
    s1 = 8'h55; s2 = 8'hAA;
    #2;

    // Reset wins over a simultaneous load of a non-zero bus.
    arst = 1'b1; a_yukle = 1'b1; s1_yolla = 8'hFF;
    step();
    clear_inputs();
    #1;
    check("rst_a",      a_tb,      8'h00);
    check("rst_b",      b_tb,      8'h00);
    check("rst_ar",     m_address, 8'h00);
    check("rst_bus",    to_memory, 8'h00);
    check("rst_alu_add", alu_result_tb, 8'h00);
    alu_sel = 3'd5; #1;
    check("rst_alu_not", alu_result_tb, 8'hFF);
    alu_sel = 3'd0;

    // Load A from s1.
    s1 = 8'h18; s1_yolla = 8'hFF; a_yukle = 1'b1; #1;
    check("s1_bus_pre", to_memory, 8'h18);
    step();
    a_yukle = 1'b0; #1;
    check("a_loaded", a_tb, 8'h18);

    // Load B from s2, then exercise the ALU.
    s1_yolla = 8'h00; s2 = 8'h03; s2_yolla = 8'hFF; b_yukle = 1'b1; alu_sel = 3'd0;
    step();
    b_yukle = 1'b0; #1;
    check("b_loaded", b_tb,          8'h03);
    check("alu_add",  alu_result_tb, 8'h1B);
    alu_sel = 3'd1; #1;
    check("alu_sub",  alu_result_tb, 8'h15);
    alu_sel = 3'd6; #1;
    check("alu_shl",  alu_result_tb, 8'h30);
    alu_sel = 3'd7; #1;
    check("alu_shr",  alu_result_tb, 8'h0C);
    alu_sel = 3'd2; #1;
    check("alu_and",  alu_result_tb, 8'h00);
    alu_sel = 3'd0;

    // B drives the bus; nothing loads.
    s2_yolla = 8'h00; b_yolla = 8'hFF; #1;
    check("b_drive", to_memory, 8'h03);
    b_yolla = 8'h00; #1;
    check("bus_idle", to_memory, 8'h00);
    step();
    check("hold_a", a_tb, 8'h18);
    check("hold_b", b_tb, 8'h03);

    // Partial masks from two sources merge bitwise.
    s1_yolla = 8'h0F; s2_yolla = 8'hF0; #1;
    check("merge_bus", to_memory, 8'h08);
    s1_yolla = 8'hFF; s2_yolla = 8'h0F; #1;
    check("overlap_bus", to_memory, 8'h1B);
    s2_yolla = 8'h00; ar_yukle = 1'b1;
    step();
    ar_yukle = 1'b0; s1_yolla = 8'h00; #1;
    check("ar_loaded", m_address, 8'h18);

    // A drives and loads in the same cycle while B loads the same value.
    a_yolla = 8'hFF; a_yukle = 1'b1; b_yukle = 1'b1;
    step();
    clear_inputs(); alu_sel = 3'd4; #1;
    check("self_load_a", a_tb,          8'h18);
    check("copy_b",      b_tb,          8'h18);
    check("alu_xor",     alu_result_tb, 8'h00);

    // Randomized traffic; the compare process checks every cycle.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      arst     = ($urandom_range(31) == 0);
      alu_sel  = 3'($urandom);
      a_yolla  = rand_mask();
      b_yolla  = rand_mask();
      ar_yolla = rand_mask();
      s1_yolla = rand_mask();
      s2_yolla = rand_mask();
      s1       = 8'($urandom);
      s2       = 8'($urandom);
      a_yukle  = 1'($urandom);
      b_yukle  = 1'($urandom);
      ar_yukle = 1'($urandom);
      step();
    end

    @(negedge aclk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
